// File: rtl/lcd_pkg.sv
// Shared LCD constants: mode encodings, init table and default bus timing,
// so the main controller and the bus driver agree on one set of values.
package lcd_pkg;

    localparam logic LCD_INIT = 1'b1;
    localparam logic LCD_REF  = 1'b0;

    localparam int INIT_CONST_NO = 4;
    localparam int REF_DATA_NO   = 16;

    localparam logic [7:0] INIT_FUNC_SET   = 8'h38;
    localparam logic [7:0] INIT_DISP_ON    = 8'h0C;
    localparam logic [7:0] INIT_ENTRY_MODE = 8'h06;
    localparam logic [7:0] INIT_CLEAR      = 8'h01;

    // Defaults assume a 50 MHz clock.
    localparam int DEF_T_PWR   = 2_000_000;
    localparam int DEF_T_AS    = 2;
    localparam int DEF_T_EH    = 12;
    localparam int DEF_T_H     = 2;
    localparam int DEF_T_EXEC  = 2000;
    localparam int DEF_T_CLEAR = 80_000;
    localparam int DEF_CNT_W   = 21;

    typedef struct packed {
        logic mode;
        logic db_sel;
        logic reg_sel;
    } lcd_req_t;

    function automatic logic [7:0] init_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    return INIT_FUNC_SET;
            4'd1:    return INIT_DISP_ON;
            4'd2:    return INIT_ENTRY_MODE;
            4'd3:    return INIT_CLEAR;
            default: return 8'h00;
        endcase
    endfunction

    // Clear display / return home need the long execution wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b <= 8'h03);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
module lcd_delay_counter #(
    parameter int               CNT_W   = 21,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = value;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= RST_VAL;
        else
            cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780-style bus driver: runs init-table, single-command or refresh-line
// transactions with setup / E-pulse / hold / execution-wait timing.
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int T_PWR   = DEF_T_PWR,
    parameter int T_AS    = DEF_T_AS,
    parameter int T_EH    = DEF_T_EH,
    parameter int T_H     = DEF_T_H,
    parameter int T_EXEC  = DEF_T_EXEC,
    parameter int T_CLEAR = DEF_T_CLEAR,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_enable,
    input  logic       mode,
    input  logic       db_sel,
    input  logic       reg_sel,
    input  logic [7:0] data_in,
    output logic [3:0] data_idx,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db,
    output logic       lcd_finish,
    output logic       busy
);

    localparam logic [2:0] S_POWERUP = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_PULSE   = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;

    logic [2:0]  state_q, state_d;
    lcd_req_t    req_q, req_d, req_in, start_req;
    logic        pend_q, pend_d;
    logic [4:0]  nbytes_q, nbytes_d;
    logic [3:0]  byte_q, byte_d;
    logic [3:0]  idx_q, idx_d;
    logic        e_q, e_d, rs_q, rs_d, fin_q, fin_d, busy_q, busy_d;
    logic [7:0]  db_q, db_d;
    logic        start, last, src_tab;
    logic        ld, done;
    logic [CNT_W-1:0] ld_val;

    lcd_delay_counter #(
        .CNT_W  (CNT_W),
        .RST_VAL(CNT_W'(T_PWR - 1))
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .load (ld),
        .value(ld_val),
        .done (done)
    );

    assign req_in  = {mode, db_sel, reg_sel};
    assign src_tab = (req_q.mode == LCD_INIT) && req_q.db_sel;
    assign last    = ({1'b0, byte_q} == nbytes_q - 5'd1);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        pend_d    = pend_q;
        nbytes_d  = nbytes_q;
        byte_d    = byte_q;
        idx_d     = idx_q;
        e_d       = e_q;
        rs_d      = rs_q;
        db_d      = db_q;
        fin_d     = 1'b0;
        ld        = 1'b0;
        ld_val    = '0;
        start     = 1'b0;
        start_req = req_in;

        case (state_q)
            S_POWERUP: begin
                // A start seen during power-up is held until the wait expires.
                if (lcd_enable) begin
                    pend_d = 1'b1;
                    req_d  = req_in;
                end
                if (done) begin
                    pend_d    = 1'b0;
                    start_req = lcd_enable ? req_in : req_q;
                    if (lcd_enable || pend_q)
                        start = 1'b1;
                    else
                        state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (lcd_enable)
                    start = 1'b1;
            end
            S_SETUP: begin
                if (done) begin
                    state_d = S_PULSE;
                    e_d     = 1'b1;
                    ld      = 1'b1;
                    ld_val  = CNT_W'(T_EH - 1);
                end
            end
            S_PULSE: begin
                if (done) begin
                    state_d = S_HOLD;
                    e_d     = 1'b0;
                    ld      = 1'b1;
                    ld_val  = CNT_W'(T_H - 1);
                end
            end
            S_HOLD: begin
                if (done) begin
                    state_d = S_WAIT;
                    ld      = 1'b1;
                    ld_val  = is_slow_cmd(rs_q, db_q) ? CNT_W'(T_CLEAR - 1)
                                                      : CNT_W'(T_EXEC - 1);
                    // Advance early so data_in for the next byte settles
                    // during the wait and is ready when SETUP is entered.
                    if (!last && !src_tab)
                        idx_d = idx_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (done) begin
                    if (last) begin
                        state_d = S_IDLE;
                        fin_d   = 1'b1;
                        rs_d    = 1'b0;
                        db_d    = 8'h00;
                        idx_d   = 4'd0;
                    end else begin
                        state_d = S_SETUP;
                        byte_d  = byte_q + 4'd1;
                        db_d    = src_tab ? init_byte(byte_q + 4'd1) : data_in;
                        ld      = 1'b1;
                        ld_val  = CNT_W'(T_AS - 1);
                    end
                end
            end
            default: state_d = S_POWERUP;
        endcase

        if (start) begin
            state_d = S_SETUP;
            req_d   = start_req;
            byte_d  = 4'd0;
            idx_d   = 4'd0;
            rs_d    = start_req.reg_sel;
            if (start_req.mode == LCD_REF)
                nbytes_d = 5'(REF_DATA_NO);
            else if (start_req.db_sel)
                nbytes_d = 5'(INIT_CONST_NO);
            else
                nbytes_d = 5'd1;
            db_d   = (start_req.mode == LCD_INIT && start_req.db_sel) ? init_byte(4'd0) : data_in;
            ld     = 1'b1;
            ld_val = CNT_W'(T_AS - 1);
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_POWERUP;
            req_q    <= '0;
            pend_q   <= 1'b0;
            nbytes_q <= 5'd0;
            byte_q   <= 4'd0;
            idx_q    <= 4'd0;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            db_q     <= 8'h00;
            fin_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            pend_q   <= pend_d;
            nbytes_q <= nbytes_d;
            byte_q   <= byte_d;
            idx_q    <= idx_d;
            e_q      <= e_d;
            rs_q     <= rs_d;
            db_q     <= db_d;
            fin_q    <= fin_d;
            busy_q   <= busy_d;
        end
    end

    assign data_idx   = idx_q;
    assign lcd_e      = e_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_db     = db_q;
    assign lcd_finish = fin_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver with shrunk timing parameters.
module tb_lcd_bus_driver;

    logic       clk, rst, lcd_enable, mode, db_sel, reg_sel;
    logic [7:0] data_in;
    logic [3:0] data_idx;
    logic       lcd_e, lcd_rs, lcd_rw, lcd_finish, busy;
    logic [7:0] lcd_db;

    logic [7:0] din_base;
    bit         din_inc;
    int         checks, failures, cyc, cyc0;

    int         rise_cyc[$];
    logic [7:0] rise_db[$];
    logic       rise_rs[$];
    logic [3:0] rise_idx[$];
    int         width[$];
    int         fin_cyc;
    logic [7:0] fin_db;
    logic       fin_rs, fin_busy;
    logic [3:0] fin_idx;

    assign data_in = din_base + (din_inc ? {4'h0, data_idx} : 8'h00);

    lcd_bus_driver #(
        .T_PWR(10), .T_AS(1), .T_EH(2), .T_H(1), .T_EXEC(4), .T_CLEAR(8), .CNT_W(21)
    ) dut (
        .clk(clk), .rst(rst), .lcd_enable(lcd_enable), .mode(mode), .db_sel(db_sel),
        .reg_sel(reg_sel), .data_in(data_in), .data_idx(data_idx), .lcd_e(lcd_e),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db), .lcd_finish(lcd_finish),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic start(input bit m, input bit d, input bit r);
        lcd_enable = 1'b1; mode = m; db_sel = d; reg_sel = r;
        @(negedge clk);
        lcd_enable = 1'b0;
    endtask

    // Records each E rising edge and the finish cycle; optionally fires a
    // start pulse right after rise number inject_rise.
    task automatic capture(input int budget, input int inject_rise, output bit got_fin);
        int ecnt; bit pe; bit inj;
        rise_cyc.delete(); rise_db.delete(); rise_rs.delete(); rise_idx.delete(); width.delete();
        got_fin = 0; pe = lcd_e; ecnt = 0; inj = 0; fin_cyc = -1;
        for (int i = 0; i < budget && !got_fin; i++) begin
            @(negedge clk);
            if (inj) begin lcd_enable = 1'b0; inj = 0; end
            if (lcd_e && !pe) begin
                rise_cyc.push_back(cyc); rise_db.push_back(lcd_db);
                rise_rs.push_back(lcd_rs); rise_idx.push_back(data_idx);
                if (rise_cyc.size() - 1 == inject_rise) begin
                    lcd_enable = 1'b1; mode = 1'b0; db_sel = 1'b0; reg_sel = 1'b1; inj = 1;
                end
            end
            if (lcd_e) ecnt++;
            else if (pe) begin width.push_back(ecnt); ecnt = 0; end
            if (lcd_finish) begin
                got_fin = 1; fin_cyc = cyc; fin_db = lcd_db; fin_rs = lcd_rs;
                fin_busy = busy; fin_idx = data_idx;
            end
            pe = lcd_e;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (lcd_e !== 1'b0) begin failures++; $display("FAIL reset_e got=%0h exp=0", lcd_e); end
        checks++; if (lcd_rs !== 1'b0) begin failures++; $display("FAIL reset_rs got=%0h exp=0", lcd_rs); end
        checks++; if (lcd_rw !== 1'b0) begin failures++; $display("FAIL reset_rw got=%0h exp=0", lcd_rw); end
        checks++; if (lcd_db !== 8'h00) begin failures++; $display("FAIL reset_db got=%0h exp=0", lcd_db); end
        checks++; if (lcd_finish !== 1'b0) begin failures++; $display("FAIL reset_finish got=%0h exp=0", lcd_finish); end
        checks++; if (data_idx !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0h exp=0", data_idx); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%0h exp=1", busy); end
        rst = 1'b0;
        cyc0 = cyc;
    endtask

    task automatic test_init_powerup();
        logic [7:0] tbl [4];
        bit got;
        tbl = '{8'h38, 8'h0C, 8'h06, 8'h01};
        repeat (2) @(negedge clk);
        start(1'b1, 1'b1, 1'b0);
        capture(200, -1, got);
        checks++; if (!got) begin failures++; $display("FAIL init_finish_seen got=0 exp=1"); end
        checks++; if (rise_cyc.size() != 4) begin failures++; $display("FAIL init_pulse_count got=%0d exp=4", rise_cyc.size()); end
        checks++; if (rise_cyc[0] - cyc0 != 11) begin failures++; $display("FAIL init_first_rise got=%0d exp=11", rise_cyc[0] - cyc0); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rise_db[k] !== tbl[k]) begin failures++; $display("FAIL init_db%0d got=%0h exp=%0h", k, rise_db[k], tbl[k]); end
            checks++; if (rise_rs[k] !== 1'b0) begin failures++; $display("FAIL init_rs%0d got=%0h exp=0", k, rise_rs[k]); end
            checks++; if (rise_idx[k] !== 4'd0) begin failures++; $display("FAIL init_idx%0d got=%0h exp=0", k, rise_idx[k]); end
            checks++; if (width[k] != 2) begin failures++; $display("FAIL init_width%0d got=%0d exp=2", k, width[k]); end
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if (rise_cyc[k+1] - rise_cyc[k] != 8) begin failures++; $display("FAIL init_period%0d got=%0d exp=8", k, rise_cyc[k+1] - rise_cyc[k]); end
        end
        checks++; if (fin_cyc - rise_cyc[3] != 11) begin failures++; $display("FAIL init_clear_wait got=%0d exp=11", fin_cyc - rise_cyc[3]); end
        checks++; if (fin_busy !== 1'b0) begin failures++; $display("FAIL init_fin_busy got=%0h exp=0", fin_busy); end
        checks++; if (fin_db !== 8'h00) begin failures++; $display("FAIL init_fin_db got=%0h exp=0", fin_db); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (lcd_finish !== 1'b0 || lcd_e !== 1'b0) begin failures++; $display("FAIL init_quiet%0d got=fin%0h/e%0h exp=0/0", i, lcd_finish, lcd_e); end
        end
    endtask

    task automatic test_single();
        bit got; int s;
        din_base = 8'h80; din_inc = 0;
        start(1'b1, 1'b0, 1'b0);
        s = cyc;
        checks++; if (lcd_db !== 8'h80) begin failures++; $display("FAIL single_setup_db got=%0h exp=80", lcd_db); end
        checks++; if (busy !== 1'b1 || lcd_e !== 1'b0) begin failures++; $display("FAIL single_setup got=busy%0h/e%0h exp=1/0", busy, lcd_e); end
        capture(50, -1, got);
        checks++; if (!got || rise_cyc.size() != 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", rise_cyc.size()); end
        checks++; if (rise_cyc[0] - s != 1) begin failures++; $display("FAIL single_rise got=%0d exp=1", rise_cyc[0] - s); end
        checks++; if (width[0] != 2) begin failures++; $display("FAIL single_width got=%0d exp=2", width[0]); end
        checks++; if (rise_db[0] !== 8'h80 || rise_rs[0] !== 1'b0) begin failures++; $display("FAIL single_bus got=%0h/%0h exp=80/0", rise_db[0], rise_rs[0]); end
        checks++; if (fin_cyc - s != 8) begin failures++; $display("FAIL single_finish got=%0d exp=8", fin_cyc - s); end
        checks++; if (rise_idx[0] !== 4'd0 || fin_idx !== 4'd0) begin failures++; $display("FAIL single_idx got=%0h/%0h exp=0/0", rise_idx[0], fin_idx); end
    endtask

    task automatic test_refresh();
        bit got; int s; logic [7:0] exp;
        din_base = 8'h41; din_inc = 1;
        start(1'b0, 1'b0, 1'b1);
        s = cyc;
        checks++; if (lcd_db !== 8'h41 || lcd_rs !== 1'b1) begin failures++; $display("FAIL ref_setup got=%0h/%0h exp=41/1", lcd_db, lcd_rs); end
        capture(400, -1, got);
        checks++; if (!got || rise_cyc.size() != 16) begin failures++; $display("FAIL ref_pulses got=%0d exp=16", rise_cyc.size()); end
        for (int k = 0; k < 16; k++) begin
            exp = 8'h41 + 8'(k);
            checks++; if (rise_db[k] !== exp || rise_rs[k] !== 1'b1) begin failures++; $display("FAIL ref_byte%0d got=%0h/%0h exp=%0h/1", k, rise_db[k], rise_rs[k], exp); end
            checks++; if (rise_idx[k] !== 4'(k)) begin failures++; $display("FAIL ref_idx%0d got=%0d exp=%0d", k, rise_idx[k], k); end
        end
        checks++; if (fin_cyc - s != 128) begin failures++; $display("FAIL ref_finish got=%0d exp=128", fin_cyc - s); end
        checks++; if (fin_idx !== 4'd0 || fin_rs !== 1'b0) begin failures++; $display("FAIL ref_fin_idx_rs got=%0h/%0h exp=0/0", fin_idx, fin_rs); end
        din_inc = 0;
    endtask

    task automatic test_back_to_back();
        bit got; int s;
        din_base = 8'h80;
        start(1'b1, 1'b0, 1'b0);
        capture(50, -1, got);
        checks++; if (!got) begin failures++; $display("FAIL b2b_first_finish got=0 exp=1"); end
        din_base = 8'hC5;
        start(1'b1, 1'b0, 1'b1);
        checks++; if (busy !== 1'b1 || lcd_db !== 8'hC5 || lcd_rs !== 1'b1) begin failures++; $display("FAIL b2b_same_cycle got=%0h/%0h/%0h exp=1/c5/1", busy, lcd_db, lcd_rs); end
        capture(50, -1, got);
        checks++; if (!got || rise_cyc.size() != 1 || rise_db[0] !== 8'hC5) begin failures++; $display("FAIL b2b_second got=%0d/%0h exp=1/c5", rise_cyc.size(), rise_db[0]); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%0h exp=0", busy); end
        din_base = 8'h03;
        start(1'b1, 1'b0, 1'b0);
        s = cyc;
        checks++; if (busy !== 1'b1 || lcd_db !== 8'h03) begin failures++; $display("FAIL b2b_next_cycle got=%0h/%0h exp=1/03", busy, lcd_db); end
        capture(50, -1, got);
        checks++; if (fin_cyc - s != 12) begin failures++; $display("FAIL b2b_clear_boundary got=%0d exp=12", fin_cyc - s); end
    endtask

    task automatic test_ignored_start();
        bit got;
        start(1'b1, 1'b1, 1'b0);
        capture(200, 0, got);
        checks++; if (!got || rise_cyc.size() != 4) begin failures++; $display("FAIL ign_pulses got=%0d exp=4", rise_cyc.size()); end
        checks++; if (rise_db[1] !== 8'h0C || rise_rs[1] !== 1'b0) begin failures++; $display("FAIL ign_byte1 got=%0h/%0h exp=0c/0", rise_db[1], rise_rs[1]); end
        checks++; if (rise_db[3] !== 8'h01) begin failures++; $display("FAIL ign_byte3 got=%0h exp=01", rise_db[3]); end
        checks++; if (fin_cyc - rise_cyc[0] != 35) begin failures++; $display("FAIL ign_finish got=%0d exp=35", fin_cyc - rise_cyc[0]); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0 || lcd_e !== 1'b0 || lcd_finish !== 1'b0) begin failures++; $display("FAIL ign_idle%0d got=%0h/%0h/%0h exp=0/0/0", i, busy, lcd_e, lcd_finish); end
        end
    endtask

    task automatic test_reset_mid_byte();
        bit seen; int ecount;
        din_base = 8'h80; seen = 0; ecount = 0;
        start(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (lcd_e === 1'b1) seen = 1; else @(negedge clk);
        end
        checks++; if (!seen) begin failures++; $display("FAIL rst_mid_e_seen got=0 exp=1"); end
        #1 rst = 1'b1;
        #1;
        checks++; if (lcd_e !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rst_mid_async got=e%0h/busy%0h exp=0/1", lcd_e, busy); end
        checks++; if (lcd_db !== 8'h00 || lcd_rs !== 1'b0) begin failures++; $display("FAIL rst_mid_bus got=%0h/%0h exp=0/0", lcd_db, lcd_rs); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (lcd_e) ecount++;
            if (i == 9) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_pwr_busy got=%0h exp=1", busy); end
            end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_idle got=%0h exp=0", busy); end
        checks++; if (ecount != 0) begin failures++; $display("FAIL rst_mid_no_e got=%0d exp=0", ecount); end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1; lcd_enable = 1'b0; mode = 1'b0; db_sel = 1'b0; reg_sel = 1'b0;
        din_base = 8'h00; din_inc = 0;
        test_reset();
        test_init_powerup();
        test_single();
        test_refresh();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid_byte();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_bus_driver.md
# lcd_bus_driver

Executes byte transactions requested by the LCD main controller and drives the HD44780-style character-LCD bus (E, RS, RW, DB[7:0]) with correct setup, pulse-width, hold and execution-wait timing. The controller issues a one-cycle `lcd_enable` start with a `mode`/`db_sel`/`reg_sel` qualifier. The driver then sends the 4-byte init table, one command byte, or a 16-byte refresh line, and returns a one-cycle `lcd_finish`. It sits between the main controller/data mux and the FPGA pins.

## Interface
- `T_PWR`, 2_000_000: power-up wait cycles after reset (40 ms at 50 MHz)
- `T_AS`, 2: cycles RS/DB are valid before E rises
- `T_EH`, 12: E high cycles
- `T_H`, 2: cycles RS/DB are held after E falls
- `T_EXEC`, 2000: post-byte execution wait (40 µs)
- `T_CLEAR`, 80_000: post-byte wait for a clear/home command (byte ≤ 0x03 with RS=0)
- `CNT_W`, 21: delay counter width; must hold max(T_*) - 1
- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-high reset
- `lcd_enable` in 1: start pulse, sampled in IDLE/POWERUP only
- `mode` in 1: 1 = LCD_INIT, 0 = LCD_REF; sampled at start
- `db_sel` in 1: with mode=1 selects the source; 1 = internal init table (4 bytes), 0 = `data_in` (1 byte); ignored when mode=0
- `reg_sel` in 1: RS value for the whole transaction; sampled at start
- `data_in` in 8: external byte, sampled on entry to SETUP of each byte
- `data_idx` out 4: index of the current external byte; `data_in` must be valid combinationally from it
- `lcd_e`, `lcd_rs`, `lcd_rw` out 1 each: bus strobes; `lcd_rw` is constant 0
- `lcd_db` out 8: bus data
- `lcd_finish` out 1: one-cycle completion pulse
- `busy` out 1: high in every state except IDLE

## Operation
- Reset values of all outputs: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_db`=0x00, `lcd_finish`=0, `data_idx`=0, `busy`=1. State is POWERUP.
- States: POWERUP → IDLE → SETUP → PULSE → HOLD → WAIT → (SETUP for the next byte | IDLE).
- POWERUP: counts T_PWR cycles. An `lcd_enable` pulse during POWERUP is latched as pending, together with mode, db_sel and reg_sel, and starts at the end of POWERUP. A second pulse overwrites the latched request.
- IDLE: when `lcd_enable`=1, capture mode/db_sel/reg_sel and set the byte count:
  - init table: 4
  - single command: 1
  - refresh: 16
  Clear `data_idx` and go to SETUP.
- SETUP: drive `lcd_rs` and `lcd_db` for T_AS cycles. The byte is the table entry or `data_in`. Init table is 0x38, 0x0C, 0x06, 0x01 in that order.
- PULSE: `lcd_e`=1 for T_EH cycles. HOLD: `lcd_e`=0, RS/DB unchanged, for T_H cycles.
- WAIT: T_CLEAR cycles if RS=0 and the byte ≤ 0x03, otherwise T_EXEC. At the end, if bytes remain, increment `data_idx` and go to SETUP. Otherwise go to IDLE, pulse `lcd_finish`, and return `lcd_rs`/`lcd_db` to 0.
- `lcd_enable` while busy (outside POWERUP) is ignored.
- `data_idx` stays 0 for the init and single-command transactions and wraps to 0 at transaction end.

## Timing
- All outputs are registered; no combinational path from inputs to the bus pins.
- Start `lcd_enable` sampled at edge N in IDLE: SETUP from N+1, with `lcd_db`/`lcd_rs` valid from N+1.
- `lcd_e` rises at N+1+T_AS and falls T_EH cycles later.
- Per-byte period: T_AS+T_EH+T_H+wait cycles.
- `lcd_finish` is high for exactly one cycle, the first cycle in IDLE (`busy`=0 in that cycle).
- An `lcd_enable` in that same cycle or the next is accepted, so the controller can chain init → addr → ref with no gap.
- `rst` mid-transaction: bus returns to reset values immediately (E drops asynchronously), and POWERUP restarts from full T_PWR.
- Each delay loads value-1 and ends on count 0. Every T_* parameter is ≥ 1.

## Structure
- Shared package `lcd_pkg`:
  - mode encodings LCD_INIT=1, LCD_REF=0
  - INIT_CONST_NO=4, REF_DATA_NO=16
  - the init-table byte constants
  - default timing constants, so the controller and the driver agree
- One sub-module, `lcd_delay_counter`: loadable CNT_W-bit down-counter with `load`, `value`, `done`. The FSM, byte counter and table mux stay in `lcd_bus_driver`.

## Test plan
Small parameters for all scenarios: T_PWR=10, T_AS=1, T_EH=2, T_H=1, T_EXEC=4, T_CLEAR=8.
- **Init while powering up:** `lcd_enable`, mode=1, db_sel=1 in cycle 2 after reset → no E before cycle 10. Then four E pulses with DB 0x38, 0x0C, 0x06, 0x01 and RS=0. The 0x01 byte is followed by an 8-cycle wait. Then exactly one `lcd_finish`.
- **Single command:** mode=1, db_sel=0, reg_sel=0, data_in=0x80 → one E pulse 2 cycles wide, DB=0x80, RS=0. `lcd_finish` 1+2+1+4 cycles after SETUP entry. `data_idx` stays 0.
- **Refresh line:** mode=0, reg_sel=1, data_in=0x41+data_idx → 16 E pulses carrying 0x41..0x50 with RS=1. `data_idx` steps 0..15 and then returns to 0.
- **Back-to-back:** `lcd_enable` in the `lcd_finish` cycle → new SETUP on the next cycle, no lost request.
- **Ignored start:** `lcd_enable` while in PULSE → ignored; the byte sequence and finish count are unchanged.
- **Reset mid-byte:** assert `rst` while `lcd_e`=1 → `lcd_e`=0 and `busy`=1 immediately. No E pulse for 10 cycles after release.
